// File: rtl/stack_alu_if.sv
// Command/status bundle between the calculator front end and the stack_alu core.
interface stack_alu_if #(
  parameter int DATA_W = 32,
  parameter int IN_W   = 8,
  parameter int CNT_W  = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [IN_W-1:0]   cmd_data;
  logic              clr_err;
  logic [CNT_W-1:0]  depth;
  logic [DATA_W-1:0] top0;
  logic [DATA_W-1:0] top1;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_data, clr_err,
    input  cmd_ready, depth, top0, top1, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, clr_err,
    output cmd_ready, depth, top0, top1, err, err_code
  );
endinterface

// File: rtl/stack_alu.sv
// Stack-machine execution core: top two words in registers, deeper words in a
// single-port RAM, and an iterative restoring divider for DIV/MOD.
module stack_alu #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int IN_W   = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        reset,
  stack_alu_if.slave bus
);
  localparam int MEM_AW = $clog2(DEPTH - 2);
  localparam int DIV_CW = $clog2(DATA_W);

  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_EXT  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_POP  = 4'd7;
  localparam logic [3:0] OP_DUP  = 4'd8;
  localparam logic [3:0] OP_SWP  = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  localparam logic [1:0] E_UNDER = 2'd1;
  localparam logic [1:0] E_OVER  = 2'd2;
  localparam logic [1:0] E_DIV0  = 2'd3;

  logic [1:0]        state_q;
  logic              ready_q;
  logic [3:0]        op_q;
  logic [IN_W-1:0]   data_q;
  logic [1:0]        pendErr_q;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0] top0_q, top0_d;
  logic [DATA_W-1:0] top1_q, top1_d;
  logic              err_q;
  logic [1:0]        errCode_q;
  logic [DATA_W-1:0] memRdata_q;
  logic [DATA_W-1:0] mem [DEPTH-2];
  logic [DATA_W-1:0] quot_q, rem_q, divisor_q;
  logic [DIV_CW-1:0] divCnt_q;

  logic              accept;
  logic [1:0]        chkErr;
  logic              grows, shrinks, memWrite, memRead;
  logic [MEM_AW-1:0] memAddr;
  logic [DATA_W:0]   trial, trialDiff;
  logic              trialFits;
  logic [DATA_W-1:0] remNext, refill, binResult;

  assign accept = bus.cmd_valid && ready_q;

  always_comb begin
    chkErr = 2'd0;
    case (bus.cmd_op)
      OP_PUSH, OP_DUP: if (depth_q == CNT_W'(DEPTH)) chkErr = E_OVER;
      OP_EXT, OP_POP:  if (depth_q == '0) chkErr = E_UNDER;
      OP_ADD, OP_SUB, OP_MUL, OP_SWP:
                       if (depth_q < CNT_W'(2)) chkErr = E_UNDER;
      OP_DIV, OP_MOD: begin
        if (depth_q < CNT_W'(2))  chkErr = E_UNDER;
        else if (top0_q == '0)    chkErr = E_DIV0;
      end
      default:         chkErr = E_OVER;
    endcase
  end

  // Spill of the old top1 on growth and refill read of the new top1 on shrink
  // are both issued at the acceptance edge, so refill data is ready in the busy cycle.
  assign grows    = (bus.cmd_op == OP_PUSH) || (bus.cmd_op == OP_DUP);
  assign shrinks  = (bus.cmd_op >= OP_ADD) && (bus.cmd_op <= OP_POP);
  assign memWrite = accept && !reset && (chkErr == 2'd0) && grows && (depth_q >= CNT_W'(2));
  assign memRead  = accept && !reset && (chkErr == 2'd0) && shrinks && (depth_q >= CNT_W'(3));
  assign memAddr  = grows ? MEM_AW'(depth_q - CNT_W'(2)) : MEM_AW'(depth_q - CNT_W'(3));

  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[memAddr] <= top1_q;
    end else if (memRead) begin
      memRdata_q <= mem[memAddr];
    end
  end

  assign trial     = {rem_q, quot_q[DATA_W-1]};
  assign trialDiff = trial - {1'b0, divisor_q};
  assign trialFits = trial >= {1'b0, divisor_q};
  assign remNext   = trialFits ? trialDiff[DATA_W-1:0] : trial[DATA_W-1:0];
  assign refill    = (depth_q >= CNT_W'(3)) ? memRdata_q : '0;

  always_comb begin
    binResult = '0;
    case (op_q)
      OP_ADD:  binResult = top1_q + top0_q;
      OP_SUB:  binResult = top1_q - top0_q;
      OP_MUL:  binResult = top1_q * top0_q;
      OP_DIV:  binResult = quot_q;
      OP_MOD:  binResult = rem_q;
      default: binResult = '0;
    endcase
  end

  always_comb begin
    top0_d  = top0_q;
    top1_d  = top1_q;
    depth_d = depth_q;
    case (op_q)
      OP_PUSH: begin
        top0_d  = {{(DATA_W-IN_W){1'b0}}, data_q};
        top1_d  = top0_q;
        depth_d = depth_q + CNT_W'(1);
      end
      OP_EXT:  top0_d = {top0_q[DATA_W-IN_W-1:0], data_q};
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
        top0_d  = binResult;
        top1_d  = refill;
        depth_d = depth_q - CNT_W'(1);
      end
      OP_POP: begin
        top0_d  = top1_q;
        top1_d  = refill;
        depth_d = depth_q - CNT_W'(1);
      end
      OP_DUP: begin
        top1_d  = top0_q;
        depth_d = depth_q + CNT_W'(1);
      end
      OP_SWP: begin
        top0_d = top1_q;
        top1_d = top0_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      op_q      <= '0;
      data_q    <= '0;
      pendErr_q <= '0;
      depth_q   <= '0;
      top0_q    <= '0;
      top1_q    <= '0;
      err_q     <= 1'b0;
      errCode_q <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      divCnt_q  <= '0;
    end else begin
      if (bus.clr_err) begin
        err_q     <= 1'b0;
        errCode_q <= '0;
      end
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q   <= 1'b0;
            op_q      <= bus.cmd_op;
            data_q    <= bus.cmd_data;
            pendErr_q <= chkErr;
            if ((chkErr == 2'd0) && ((bus.cmd_op == OP_DIV) || (bus.cmd_op == OP_MOD))) begin
              state_q   <= ST_DIV;
              quot_q    <= top1_q;
              rem_q     <= '0;
              divisor_q <= top0_q;
              divCnt_q  <= '0;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_DIV: begin
          quot_q   <= {quot_q[DATA_W-2:0], trialFits};
          rem_q    <= remNext;
          divCnt_q <= divCnt_q + DIV_CW'(1);
          if (divCnt_q == DIV_CW'(DATA_W - 1)) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          // A rejected command only updates the sticky error; the stack is untouched.
          if (pendErr_q != 2'd0) begin
            err_q     <= 1'b1;
            errCode_q <= pendErr_q;
          end else begin
            top0_q  <= top0_d;
            top1_q  <= top1_d;
            depth_q <= depth_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.depth     = depth_q;
  assign bus.top0      = top0_q;
  assign bus.top1      = top1_q;
  assign bus.err       = err_q;
  assign bus.err_code  = errCode_q;
endmodule

// File: tb/tb_stack_alu.sv
// Scoreboard bench for stack_alu: a queue-based stack model predicts every
// command's result and busy time; a negedge monitor checks each completion.
module tb_stack_alu;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int IN_W   = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  stack_alu_if #(.DATA_W(DATA_W), .IN_W(IN_W), .CNT_W(CNT_W)) bus ();

  stack_alu #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  depth;
    logic [DATA_W-1:0] top0;
    logic [DATA_W-1:0] top1;
    logic              err;
    logic [1:0]        code;
    int                lat;
  } exp_t;

  exp_t              sbQ[$];
  logic [DATA_W-1:0] stk[$];
  logic              mErr = 1'b0;
  logic [1:0]        mCode = 2'd0;
  int                total = 0;
  int                bad = 0;
  logic              inFlight = 1'b0;
  int                busy = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference semantics of one command, written directly against a queue stack.
  task automatic modelCmd(input logic [3:0] op, input logic [IN_W-1:0] d, input logic clr, output exp_t e);
    int n;
    logic [1:0] code;
    logic [DATA_W-1:0] a, b, r;
    n = stk.size();
    code = 2'd0;
    b = (n >= 1) ? stk[n-1] : '0;
    a = (n >= 2) ? stk[n-2] : '0;
    r = '0;
    if (op > 4'd9) code = 2'd2;
    else if ((op == 4'd0 || op == 4'd8) && n == DEPTH) code = 2'd2;
    else if ((op == 4'd1 || op == 4'd7) && n < 1) code = 2'd1;
    else if (op >= 4'd2 && op <= 4'd6 && n < 2) code = 2'd1;
    else if (op == 4'd9 && n < 2) code = 2'd1;
    else if ((op == 4'd5 || op == 4'd6) && b == '0) code = 2'd3;
    if (clr) begin
      mErr = 1'b0;
      mCode = 2'd0;
    end
    if (code != 2'd0) begin
      mErr = 1'b1;
      mCode = code;
    end else begin
      case (op)
        4'd0: stk.push_back(DATA_W'(d));
        4'd1: stk[n-1] = (b << IN_W) | DATA_W'(d);
        4'd7: void'(stk.pop_back());
        4'd8: stk.push_back(b);
        4'd9: begin stk[n-1] = a; stk[n-2] = b; end
        default: begin
          case (op)
            4'd2: r = a + b;
            4'd3: r = a - b;
            4'd4: r = a * b;
            4'd5: r = a / b;
            default: r = a % b;
          endcase
          void'(stk.pop_back());
          void'(stk.pop_back());
          stk.push_back(r);
        end
      endcase
    end
    n = stk.size();
    e.depth = CNT_W'(n);
    e.top0 = (n >= 1) ? stk[n-1] : '0;
    e.top1 = (n >= 2) ? stk[n-2] : '0;
    e.err = mErr;
    e.code = mCode;
    e.lat = (code == 2'd0 && (op == 4'd5 || op == 4'd6)) ? DATA_W + 1 : 1;
  endtask

  task automatic waitReady(output logic ok);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    while (!bus.cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = bus.cmd_ready;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_wait: cmd_ready stuck at %0b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [IN_W-1:0] d, input logic clr, input logic junk);
    exp_t e;
    logic ok;
    waitReady(ok);
    if (!ok) return;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_data = d;
    bus.clr_err = clr;
    modelCmd(op, d, clr, e);
    sbQ.push_back(e);
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    bus.cmd_valid = junk;
    if (junk) begin
      bus.cmd_op = 4'($urandom);
      bus.cmd_data = IN_W'($urandom);
    end
  endtask

  task automatic waitIdle();
    logic ok;
    waitReady(ok);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " ready"}, bus.cmd_ready, 0);
    checkOutput({tag, " depth"}, bus.depth, 0);
    checkOutput({tag, " top0"}, bus.top0, 0);
    checkOutput({tag, " top1"}, bus.top1, 0);
    checkOutput({tag, " err"}, bus.err, 0);
    checkOutput({tag, " code"}, bus.err_code, 0);
  endtask

  task automatic resetDut(input string tag);
    bus.cmd_valid = 1'b0;
    bus.clr_err = 1'b0;
    reset = 1'b1;
    stk.delete();
    mErr = 1'b0;
    mCode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, " ready_after"}, bus.cmd_ready, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      inFlight = 1'b0;
      sbQ.delete();
    end else begin
      if (inFlight) begin
        if (bus.cmd_ready) begin
          inFlight = 1'b0;
          if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL spurious_completion: got completion expected none");
          end else begin
            e = sbQ.pop_front();
            checkOutput("busy_cycles", busy, e.lat);
            checkOutput("depth", bus.depth, e.depth);
            checkOutput("top0", bus.top0, e.top0);
            checkOutput("top1", bus.top1, e.top1);
            checkOutput("err", bus.err, e.err);
            checkOutput("err_code", bus.err_code, e.code);
          end
        end else begin
          busy++;
          if (busy > DATA_W + 10) begin
            total++;
            bad++;
            $display("[TB] FAIL busy_timeout: busy %0d cycles expected at most %0d", busy, DATA_W + 1);
            inFlight = 1'b0;
          end
        end
      end
      if (!inFlight && bus.cmd_ready && bus.cmd_valid) begin
        inFlight = 1'b1;
        busy = 0;
      end
    end
  end

  initial begin
    logic [63:0] sq;
    int r;
    logic [3:0] op;
    logic [IN_W-1:0] d;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_data = '0;
    bus.clr_err = 1'b0;

    resetDut("reset0");

    // Basic subtraction
    applyStimulus(4'd0, 8'd5, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd3, 1'b0, 1'b0);
    applyStimulus(4'd3, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t1 depth", bus.depth, 1);
    checkOutput("t1 top0", bus.top0, 2);
    checkOutput("t1 top1", bus.top1, 0);
    checkOutput("t1 err", bus.err, 0);

    // Divide by zero, then clear the sticky error
    resetDut("reset2");
    applyStimulus(4'd0, 8'd7, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd0, 1'b0, 1'b0);
    applyStimulus(4'd5, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t2 err", bus.err, 1);
    checkOutput("t2 code", bus.err_code, 3);
    checkOutput("t2 depth", bus.depth, 2);
    checkOutput("t2 top0", bus.top0, 0);
    checkOutput("t2 top1", bus.top1, 7);
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
    mErr = 1'b0;
    mCode = 2'd0;
    checkOutput("t2 clr err", bus.err, 0);
    checkOutput("t2 clr code", bus.err_code, 0);

    // Full-length division and modulo
    resetDut("reset3");
    applyStimulus(4'd0, 8'd100, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd7, 1'b0, 1'b0);
    applyStimulus(4'd5, 8'd0, 1'b0, 1'b1);
    waitIdle();
    checkOutput("t3 div", bus.top0, 14);
    resetDut("reset3b");
    applyStimulus(4'd0, 8'd100, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd7, 1'b0, 1'b0);
    applyStimulus(4'd6, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t3 mod", bus.top0, 2);

    // Overflow at full depth, drain to empty, then underflow
    resetDut("reset4");
    for (int i = 1; i <= DEPTH; i++) applyStimulus(4'd0, IN_W'(i), 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd9, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t4 ovf code", bus.err_code, 2);
    checkOutput("t4 ovf depth", bus.depth, DEPTH);
    checkOutput("t4 ovf top0", bus.top0, DEPTH);
    checkOutput("t4 ovf top1", bus.top1, DEPTH - 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(4'd7, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t4 empty depth", bus.depth, 0);
    checkOutput("t4 empty top0", bus.top0, 0);
    applyStimulus(4'd7, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t4 udf code", bus.err_code, 1);
    checkOutput("t4 udf depth", bus.depth, 0);

    // Extend, square, and underflowing swap
    resetDut("reset5");
    applyStimulus(4'd0, 8'h12, 1'b0, 1'b0);
    applyStimulus(4'd1, 8'h34, 1'b0, 1'b0);
    applyStimulus(4'd1, 8'h56, 1'b0, 1'b0);
    applyStimulus(4'd1, 8'h78, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t5 extend", bus.top0, 32'h12345678);
    applyStimulus(4'd8, 8'd0, 1'b0, 1'b0);
    applyStimulus(4'd4, 8'd0, 1'b0, 1'b0);
    waitIdle();
    sq = 64'h12345678 * 64'h12345678;
    checkOutput("t5 mul", bus.top0, {32'd0, sq[31:0]});
    applyStimulus(4'd9, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t5 swp code", bus.err_code, 1);
    checkOutput("t5 swp top0", bus.top0, {32'd0, sq[31:0]});

    // Reset in the middle of a division, then an illegal opcode
    resetDut("reset6");
    applyStimulus(4'd0, 8'd100, 1'b0, 1'b0);
    applyStimulus(4'd0, 8'd7, 1'b0, 1'b0);
    applyStimulus(4'd5, 8'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    resetDut("reset6 mid-div");
    checkOutput("t6 depth", bus.depth, 0);
    applyStimulus(4'd12, 8'd0, 1'b0, 1'b0);
    waitIdle();
    checkOutput("t6 illegal", bus.err_code, 2);

    // Randomized command mix against the model
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 25)      op = 4'd0;
      else if (r < 33) op = 4'd1;
      else if (r < 43) op = 4'd2;
      else if (r < 50) op = 4'd3;
      else if (r < 57) op = 4'd4;
      else if (r < 64) op = 4'd5;
      else if (r < 70) op = 4'd6;
      else if (r < 80) op = 4'd7;
      else if (r < 88) op = 4'd8;
      else if (r < 96) op = 4'd9;
      else             op = 4'($urandom_range(10, 15));
      d = ($urandom_range(0, 3) == 0) ? '0 : IN_W'($urandom);
      applyStimulus(op, d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
      if (k == 200) begin
        waitIdle();
        resetDut("reset rand");
      end
    end
    waitIdle();
    for (int i = 0; i < 10 && sbQ.size() != 0; i++) @(posedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
